// File: rtl/unidade_mult_div_if.sv
// Handshake and result bus of the iterative multiply/divide unit.
// The master side (control path / bench) issues operations; the slave side
// (unidade_mult_div) returns HI/LO, status and the register-file writeback.
interface unidade_mult_div_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] operando_a;
  logic [DATA_WIDTH-1:0] operando_b;
  logic                  escreve_rd;
  logic [4:0]            rd;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic                  div_zero;
  logic                  wb_reg_write;
  logic [4:0]            wb_reg;
  logic [DATA_WIDTH-1:0] wb_dado;

  modport master (
    output start, op, operando_a, operando_b, escreve_rd, rd,
    input  busy, done, hi, lo, div_zero, wb_reg_write, wb_reg, wb_dado
  );

  modport slave (
    input  start, op, operando_a, operando_b, escreve_rd, rd,
    output busy, done, hi, lo, div_zero, wb_reg_write, wb_reg, wb_dado
  );

endinterface

// File: rtl/unidade_mult_div.sv
// Iterative multiply/divide unit.
// Signed operations run on operand magnitudes and fix the sign at the end.
// Multiply is shift-add on a 2*DATA_WIDTH accumulator. Divide is restoring
// division, one quotient bit per cycle. The LO result is written back to the
// register file when requested.
module unidade_mult_div #(
  parameter int DATA_WIDTH = 32,
  parameter int CONT_WIDTH = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  unidade_mult_div_if.slave bus
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CALCULA  = 2'd1,
    FINALIZA = 2'd2
  } estado_t;

  // Two's-complement magnitude; unsigned operands pass through untouched
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic signed_op);
    logic [W-1:0] m;
    if (signed_op && v[W-1]) begin
      m = ~v + {{(W-1){1'b0}}, 1'b1};
    end else begin
      m = v;
    end
    return m;
  endfunction

  estado_t               state_r;
  estado_t               state_s;
  logic                  busy_r;
  logic                  busy_s;
  logic                  done_r;
  logic                  done_s;
  logic                  wb_write_r;
  logic                  wb_write_s;
  logic                  load_s;
  logic                  iter_s;
  logic                  finish_s;

  logic [CONT_WIDTH-1:0] cnt_r;
  logic [2*W-1:0]        acc_r;
  logic [W-1:0]          opnd_r;
  logic [W-1:0]          a_raw_r;
  logic [W-1:0]          hi_r;
  logic [W-1:0]          lo_r;
  logic                  is_div_r;
  logic                  neg_lo_r;
  logic                  neg_hi_r;
  logic                  dz_r;
  logic                  div_zero_r;
  logic                  wr_en_r;
  logic [4:0]            rd_r;

  // Decode of the request as seen on the start edge
  logic                  sgn_s;
  logic                  div_op_s;
  logic [W-1:0]          mag_a_s;
  logic [W-1:0]          mag_b_s;
  logic                  a_neg_s;
  logic                  b_neg_s;

  assign sgn_s    = ~bus.op[0];
  assign div_op_s = bus.op[1];
  assign mag_a_s  = magnitude(bus.operando_a, sgn_s);
  assign mag_b_s  = magnitude(bus.operando_b, sgn_s);
  assign a_neg_s  = sgn_s & bus.operando_a[W-1];
  assign b_neg_s  = sgn_s & bus.operando_b[W-1];

  // One multiply step: add multiplicand when the current multiplier bit is set,
  // then shift the whole accumulator right (multiplier bits retire from the bottom)
  logic [W:0]            mul_sum_s;
  logic [2*W-1:0]        mul_next_s;
  assign mul_sum_s  = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, opnd_r} : {(W+1){1'b0}});
  assign mul_next_s = {mul_sum_s, acc_r[W-1:1]};

  // One restoring-division step: upper half is the partial remainder, lower
  // half shifts the dividend out and the quotient in
  logic [W:0]            div_shift_s;
  logic [W:0]            div_trial_s;
  logic [2*W-1:0]        div_next_s;
  assign div_shift_s = {acc_r[2*W-1:W], acc_r[W-1]};
  assign div_trial_s = div_shift_s - {1'b0, opnd_r};
  assign div_next_s  = div_trial_s[W] ? {div_shift_s[W-1:0], acc_r[W-2:0], 1'b0}
                                      : {div_trial_s[W-1:0], acc_r[W-2:0], 1'b1};

  // Sign-corrected views of the finished accumulator
  logic [2*W-1:0]        prod_s;
  logic [W-1:0]          quot_s;
  logic [W-1:0]          rem_s;
  logic [W-1:0]          res_hi_s;
  logic [W-1:0]          res_lo_s;
  assign prod_s = neg_lo_r ? (~acc_r + {{(2*W-1){1'b0}}, 1'b1}) : acc_r;
  assign quot_s = neg_lo_r ? (~acc_r[W-1:0] + {{(W-1){1'b0}}, 1'b1}) : acc_r[W-1:0];
  assign rem_s  = neg_hi_r ? (~acc_r[2*W-1:W] + {{(W-1){1'b0}}, 1'b1}) : acc_r[2*W-1:W];

  // Final HI/LO selection: product halves, quotient/remainder, or the divide-by-zero pattern
  always_comb begin
    res_hi_s = prod_s[2*W-1:W];
    res_lo_s = prod_s[W-1:0];
    if (is_div_r) begin
      if (dz_r) begin
        res_hi_s = a_raw_r;
        res_lo_s = {W{1'b1}};
      end else begin
        res_hi_s = rem_s;
        res_lo_s = quot_s;
      end
    end else begin
      res_hi_s = prod_s[2*W-1:W];
      res_lo_s = prod_s[W-1:0];
    end
  end

  // Control FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= OCIOSO;
    end else begin
      state_r <= state_s;
    end
  end

  // Control FSM next state, datapath strobes and next values of the status outputs
  always_comb begin
    state_s    = state_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    wb_write_s = 1'b0;
    load_s     = 1'b0;
    iter_s     = 1'b0;
    finish_s   = 1'b0;
    case (state_r)
      OCIOSO: begin
        if (bus.start) begin
          state_s = CALCULA;
          busy_s  = 1'b1;
          load_s  = 1'b1;
        end else begin
          busy_s  = 1'b0;
        end
      end
      CALCULA: begin
        if (cnt_r == CONT_WIDTH'(W)) begin
          state_s    = FINALIZA;
          finish_s   = 1'b1;
          done_s     = 1'b1;
          wb_write_s = wr_en_r && (rd_r != 5'd0);
        end else begin
          iter_s     = 1'b1;
        end
      end
      FINALIZA: begin
        state_s = OCIOSO;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = OCIOSO;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Registered status outputs: busy level, one-cycle done and writeback strobe
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      wb_write_r <= 1'b0;
    end else begin
      busy_r     <= busy_s;
      done_r     <= done_s;
      wb_write_r <= wb_write_s;
    end
  end

  // Datapath: latch the request, iterate, then publish the sign-corrected result
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r      <= {CONT_WIDTH{1'b0}};
      acc_r      <= {(2*W){1'b0}};
      opnd_r     <= {W{1'b0}};
      a_raw_r    <= {W{1'b0}};
      hi_r       <= {W{1'b0}};
      lo_r       <= {W{1'b0}};
      is_div_r   <= 1'b0;
      neg_lo_r   <= 1'b0;
      neg_hi_r   <= 1'b0;
      dz_r       <= 1'b0;
      div_zero_r <= 1'b0;
      wr_en_r    <= 1'b0;
      rd_r       <= 5'd0;
    end else if (load_s) begin
      cnt_r      <= {CONT_WIDTH{1'b0}};
      acc_r      <= {{W{1'b0}}, (div_op_s ? mag_a_s : mag_b_s)};
      opnd_r     <= div_op_s ? mag_b_s : mag_a_s;
      a_raw_r    <= bus.operando_a;
      is_div_r   <= div_op_s;
      neg_lo_r   <= a_neg_s ^ b_neg_s;
      neg_hi_r   <= a_neg_s;
      dz_r       <= div_op_s && (bus.operando_b == {W{1'b0}});
      div_zero_r <= 1'b0;
      wr_en_r    <= bus.escreve_rd;
      rd_r       <= bus.rd;
    end else if (iter_s) begin
      acc_r      <= is_div_r ? div_next_s : mul_next_s;
      cnt_r      <= cnt_r + {{(CONT_WIDTH-1){1'b0}}, 1'b1};
    end else if (finish_s) begin
      hi_r       <= res_hi_s;
      lo_r       <= res_lo_s;
      div_zero_r <= is_div_r & dz_r;
    end else begin
      hi_r       <= hi_r;
      lo_r       <= lo_r;
    end
  end

  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.hi           = hi_r;
  assign bus.lo           = lo_r;
  assign bus.div_zero     = div_zero_r;
  assign bus.wb_reg_write = wb_write_r;
  assign bus.wb_reg       = rd_r;
  assign bus.wb_dado      = lo_r;

endmodule

// File: tb/tb_unidade_mult_div.sv
// Scoreboard bench for unidade_mult_div: stimulus pushes the expected result
// from an arithmetic reference model, a monitor pops it on every done pulse.
module tb_unidade_mult_div;

  localparam int W = 32;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  unidade_mult_div_if #(.DATA_WIDTH(W)) bus ();

  unidade_mult_div #(.DATA_WIDTH(W), .CONT_WIDTH(6)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic        wb;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operand values
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic wr, input logic [4:0] rd);
    exp_t        e;
    logic [63:0] p;
    longint      sa;
    longint      sb;
    e.dz = 1'b0;
    e.wb = wr && (rd != 5'd0);
    e.rd = rd;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    case (op)
      2'b00: begin p = 64'(sa * sb); e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF;
          e.hi = a;
          e.dz = 1'b1;
        end else if (op == 2'b10) begin
          e.lo = 32'(sa / sb);
          e.hi = 32'(sa % sb);
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: compare every done pulse with the oldest expectation; flag stray strobes
  always @(negedge clock) begin
    if (reset_n && bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no completion (t=%0t)", $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("hi", 64'(bus.hi), 64'(mon_e.hi));
        check("lo", 64'(bus.lo), 64'(mon_e.lo));
        check("div_zero", 64'(bus.div_zero), 64'(mon_e.dz));
        check("wb_reg_write", 64'(bus.wb_reg_write), 64'(mon_e.wb));
        check("wb_dado", 64'(bus.wb_dado), 64'(mon_e.lo));
        check("busy_at_done", 64'(bus.busy), 64'd1);
        if (mon_e.wb) begin
          check("wb_reg", 64'(bus.wb_reg), 64'(mon_e.rd));
        end
      end
    end else if (reset_n && bus.wb_reg_write !== 1'b0) begin
      n_vec++;
      n_err++;
      $display("FAIL wb_strobe_without_done: got %b expected 0 (t=%0t)", bus.wb_reg_write, $time);
    end
  end

  // Issue one operation and follow it to completion; optionally re-pulse start mid-run
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic wr, input logic [4:0] rd, input bit retrigger);
    int lat;
    bit busy_ok;
    @(negedge clock);
    bus.start      = 1'b1;
    bus.op         = op;
    bus.operando_a = a;
    bus.operando_b = b;
    bus.escreve_rd = wr;
    bus.rd         = rd;
    sb_q.push_back(model(op, a, b, wr, rd));
    @(posedge clock);
    #1;
    bus.start      = 1'b0;
    bus.op         = 2'($urandom);
    bus.operando_a = $urandom;
    bus.operando_b = $urandom;
    bus.escreve_rd = 1'($urandom);
    bus.rd         = 5'($urandom);
    busy_ok = (bus.busy === 1'b1);
    check("div_zero_cleared_on_start", 64'(bus.div_zero), 64'd0);
    lat = 0;
    do begin
      @(posedge clock);
      #1;
      lat++;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      bus.start = (retrigger && lat == 10) ? 1'b1 : 1'b0;
    end while (bus.done !== 1'b1 && lat < 100);
    bus.start = 1'b0;
    check("latency", 64'(lat), 64'd33);
    check("busy_continuous", 64'(busy_ok), 64'd1);
    @(posedge clock);
    #1;
    check("idle_after_done", 64'({bus.busy, bus.done}), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0:       v = 32'd0;
      1:       v = 32'd1;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start      = 1'b0;
    bus.op         = 2'b00;
    bus.operando_a = 32'd0;
    bus.operando_b = 32'd0;
    bus.escreve_rd = 1'b0;
    bus.rd         = 5'd0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_div_zero", 64'(bus.div_zero), 64'd0);
    check("rst_wb_reg_write", 64'(bus.wb_reg_write), 64'd0);
    check("rst_wb_reg", 64'(bus.wb_reg), 64'd0);
    reset_n = 1'b1;

    // Largest unsigned product with writeback to $5
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd5, 1'b0);

    // Reset in the middle of a multiply aborts it
    @(negedge clock);
    bus.start      = 1'b1;
    bus.op         = 2'b00;
    bus.operando_a = 32'h1234_5678;
    bus.operando_b = 32'h0000_0100;
    bus.escreve_rd = 1'b1;
    bus.rd         = 5'd9;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_hi", 64'(bus.hi), 64'd0);
    check("abort_lo", 64'(bus.lo), 64'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (40) @(posedge clock);
    run_op(2'b00, 32'd6, 32'd7, 1'b1, 5'd3, 1'b0);

    // Signed multiply with an ignored start pulse while busy
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 5'd4, 1'b1);

    // Divides: signed truncation, unsigned, by zero, signed overflow
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd8, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b1, 5'd8, 1'b0);
    run_op(2'b10, 32'h1234_5678, 32'd0, 1'b1, 5'd10, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd11, 1'b0);

    // Back-to-back start with $0 destination: no writeback strobe
    run_op(2'b01, 32'd9, 32'd11, 1'b1, 5'd0, 1'b0);

    // Randomized mix with corner-biased operands
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), pick(), pick(), 1'($urandom), 5'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    repeat (5) @(posedge clock);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/unidade_mult_div.md
Name: unidade_mult_div

Overview:
Iterative multiply/divide unit downstream of banco_registradores.
- Consumes the two read operands (dado1, dado2) and produces 32/64-bit results in HI/LO.
- Feeds the LO result back into the register file write port (reg_write / reg_escrita / escreve_dado) through the writeback mux.
- Multi-cycle with start/busy/done handshake; the control FSM stalls the PC while busy.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.
- CONT_WIDTH, 6, iteration counter width; must hold DATA_WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request operation; sampled only in OCIOSO.
- op  in  2  00 mult signed, 01 multu, 10 div signed, 11 divu.
- operando_a  in  DATA_WIDTH  multiplicand / dividend (dado1).
- operando_b  in  DATA_WIDTH  multiplier / divisor (dado2).
- escreve_rd  in  1  request writeback of LO on completion.
- rd  in  5  destination register for writeback.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- hi  out  DATA_WIDTH  product upper half / remainder.
- lo  out  DATA_WIDTH  product lower half / quotient.
- div_zero  out  1  last division had divisor 0; sticky until next accepted start.
- wb_reg_write  out  1  write strobe toward banco_registradores.
- wb_reg  out  5  destination register toward banco_registradores.
- wb_dado  out  DATA_WIDTH  data toward banco_registradores; equals lo.

Behaviour:
- Reset (async, reset_n=0): state OCIOSO; busy=0, done=0, hi=0, lo=0, div_zero=0, wb_reg_write=0, wb_reg=0; counter=0.
- Reset mid-operation aborts immediately. No done or wb strobe is produced and HI/LO are cleared.
- FSM states: OCIOSO, CALCULA, FINALIZA.
- OCIOSO -> CALCULA on the edge where start=1:
  - latch op, escreve_rd, rd;
  - latch operand magnitudes (abs value for signed ops) and the result sign;
  - counter <= 0; div_zero cleared.
- start while busy=1 or in FINALIZA is ignored; no queueing.
- CALCULA runs one iteration per edge, DATA_WIDTH edges total, then goes to FINALIZA.
  - Multiply: shift-add on a 2*DATA_WIDTH accumulator.
  - Divide: restoring division, one quotient bit per cycle.
- FINALIZA lasts exactly 1 cycle.
  - Apply sign correction; hi/lo update on entry and hold until the next accepted start.
  - done=1 for this cycle.
  - wb_reg_write=escreve_rd and rd!=0 (rd=$0 suppresses the write; $31 writes are already blocked by the register file).
  - Returns to OCIOSO.
- busy = (state != OCIOSO). It is high from the edge sampling start through the FINALIZA cycle.
- Latency: start sampled at edge E0; done high in the cycle after edge E(DATA_WIDTH+1), i.e. 33 cycles for the default.
- Multiply: {hi,lo} = full 2*DATA_WIDTH product. Signed uses two's complement; multu treats operands as unsigned.
- Divide: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Division by zero:
  - lo=all ones, hi=operando_a as latched, div_zero=1;
  - same latency; writeback still occurs if requested.
- Signed overflow, -2^(W-1) / -1: lo=0x80000000, hi=0, div_zero=0.
- Operand inputs may change after the start edge; only latched values are used.
- wb_dado is always equal to lo. wb_reg holds the latched rd.

Test Plan:
- Reset mid-op: start mult at E0, drop reset_n at E10 for 1 cycle.
  - Required: busy=0 and hi=lo=0 immediately; no done.
  - A following start of 6*7 completes normally with lo=42.
- multu 0xFFFFFFFF*0xFFFFFFFF, escreve_rd=1, rd=5.
  - Required: done after 33 cycles, hi=0xFFFFFFFE, lo=0x00000001.
  - wb_reg_write pulses 1 cycle with wb_reg=5, wb_dado=1.
- mult signed -3*7.
  - Required: hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - start re-asserted at cycle 10 is ignored: exactly one done, busy continuous.
- div signed -7/2.
  - Required: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu 100/7: lo=14, hi=2.
- div 0x12345678/0.
  - Required: div_zero=1, lo=0xFFFFFFFF, hi=0x12345678.
  - Next start clears div_zero; signed 0x80000000/-1 gives lo=0x80000000, hi=0.
- Back-to-back and $0 suppression: issue start in the OCIOSO cycle right after done, with rd=0 and escreve_rd=1.
  - Required: accepted, completes in 33 cycles, wb_reg_write stays 0.
